// File: rtl/jpeg_byte_stuffer_if.sv
// Stream bundle for jpeg_byte_stuffer.
//   in_*   : packed 32-bit entropy-coded words from the packer (no backpressure)
//   out_*  : stuffed, re-packed 32-bit words with MSB-aligned byte keep
// master = upstream producer / downstream sink side, slave = the stuffer.
interface jpeg_byte_stuffer_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_sop;
  logic        out_eop;

  modport master (
    output in_valid, in_data, in_sop, in_eop, out_ready,
    input  out_valid, out_data, out_keep, out_sop, out_eop
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, out_ready,
    output out_valid, out_data, out_keep, out_sop, out_eop
  );
endinterface

// File: rtl/jpeg_byte_stuffer.sv
// JPEG byte stuffer: inserts 0x00 after every 0xFF of the entropy-coded
// stream, appends EOI (FF D9) after each frame's last word, and re-packs
// the bytes into 32-bit words with MSB-aligned keep.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : input/output stream bundle (slave modport)
//   overflow     : sticky, an expanded word was dropped for lack of FIFO space
//   protocol_err : sticky, sop/eop sequencing violation observed
// Pipeline: sample/expand (edge N) -> FIFO write (N+1) -> output reg (N+2).
module jpeg_byte_stuffer #(
  parameter int DEPTH_BYTES = 64
) (
  input  logic                clk,
  input  logic                rst,
  jpeg_byte_stuffer_if.slave  bus,
  output logic                overflow,
  output logic                protocol_err
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = AW + 1;

  if (DEPTH_BYTES < 16 || (1 << AW) != DEPTH_BYTES) begin : g_bad_depth
    $error("DEPTH_BYTES must be a power of 2 and >= 16");
  end

  // FIFO entry: {sop, last, byte}
  typedef enum logic {IDLE, STREAM} state_e;

  state_e state_q, state_d;
  logic   accept_c, perr_set_c;

  // ---------------- frame FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.in_valid) begin
      case (state_q)
        IDLE:    if (bus.in_sop && !bus.in_eop) state_d = STREAM;
        STREAM:  if (bus.in_eop) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    accept_c   = bus.in_valid && (state_q == STREAM || bus.in_sop);
    perr_set_c = bus.in_valid &&
                 ((state_q == IDLE && !bus.in_sop) || (state_q == STREAM && bus.in_sop));
  end

  // ---------------- expansion stage ----------------
  logic [9:0][9:0] exp_c, exp_q;
  logic [3:0]      n_c, exp_n_q;
  logic            exp_vld_q;

  always_comb begin
    exp_c = '0;
    n_c   = '0;
    for (int b = 0; b < 4; b++) begin
      exp_c[n_c] = {bus.in_sop && (b == 0), 1'b0, bus.in_data[31-8*b -: 8]};
      n_c = n_c + 4'd1;
      if (bus.in_data[31-8*b -: 8] == 8'hFF) begin
        exp_c[n_c] = 10'h000;
        n_c = n_c + 4'd1;
      end
    end
    // EOI marker bytes are never stuffed
    if (bus.in_eop) begin
      exp_c[n_c] = {2'b00, 8'hFF};
      n_c = n_c + 4'd1;
      exp_c[n_c] = {2'b01, 8'hD9};
      n_c = n_c + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_vld_q <= 1'b0;
      exp_n_q   <= '0;
      exp_q     <= '0;
    end else begin
      exp_vld_q <= accept_c;
      if (accept_c) begin
        exp_q   <= exp_c;
        exp_n_q <= n_c;
      end
    end
  end

  // ---------------- byte FIFO ----------------
  logic [9:0]      mem [DEPTH_BYTES];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d, free_c;
  logic [3:0][9:0] peek_c;
  logic [2:0]      k_c;
  logic            found_c, can_pop_c, pop_c, wr_c;
  logic            out_valid_q;

  always_comb begin
    for (int i = 0; i < 4; i++) peek_c[i] = mem[rd_ptr_q + AW'(i)];
  end

  // Pop size: up to and including the first last-tagged byte, at most 4,
  // so a word never straddles two frames.
  always_comb begin
    k_c     = 3'd4;
    found_c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found_c && (CW'(i) < cnt_q) && peek_c[i][8]) begin
        found_c = 1'b1;
        k_c     = 3'(i + 1);
      end
    end
    can_pop_c = found_c || (cnt_q >= CW'(4));
    pop_c     = can_pop_c && (!out_valid_q || bus.out_ready);
    // free space after this cycle's pop
    free_c = CW'(DEPTH_BYTES) - cnt_q + (pop_c ? CW'(k_c) : {CW{1'b0}});
    wr_c   = exp_vld_q && (free_c >= CW'(exp_n_q));
    cnt_d  = cnt_q + (wr_c ? CW'(exp_n_q) : {CW{1'b0}}) - (pop_c ? CW'(k_c) : {CW{1'b0}});
  end

  always_ff @(posedge clk) begin
    if (wr_c) begin
      for (int i = 0; i < 10; i++) begin
        if (4'(i) < exp_n_q) mem[wr_ptr_q + AW'(i)] <= exp_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_c)  wr_ptr_q <= wr_ptr_q + AW'(exp_n_q);
      if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(k_c);
      cnt_q <= cnt_d;
    end
  end

  // ---------------- output packer ----------------
  logic [31:0] data_c, out_data_q;
  logic [3:0]  keep_c, out_keep_q;
  logic        sop_c, out_sop_q, out_eop_q;

  always_comb begin
    data_c = '0;
    keep_c = '0;
    sop_c  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < k_c) begin
        data_c[31-8*i -: 8] = peek_c[i][7:0];
        keep_c[3-i]         = 1'b1;
        sop_c               = sop_c | peek_c[i][9];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else if (pop_c) begin
      out_valid_q <= 1'b1;
      out_data_q  <= data_c;
      out_keep_q  <= keep_c;
      out_sop_q   <= sop_c;
      out_eop_q   <= found_c;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // ---------------- sticky flags ----------------
  logic overflow_q, perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      overflow_q <= overflow_q | (exp_vld_q & ~wr_c);
      perr_q     <= perr_q | perr_set_c;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign overflow      = overflow_q;
  assign protocol_err  = perr_q;

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
module tb_jpeg_byte_stuffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic overflow, protocol_err;
  int   total = 0;
  int   passed = 0;
  logic [37:0] q[$];   // {data, keep, sop, eop}

  always #5 clk = ~clk;

  jpeg_byte_stuffer_if bus();

  jpeg_byte_stuffer #(.DEPTH_BYTES(64)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .overflow(overflow), .protocol_err(protocol_err)
  );

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    bus.out_ready = 1'b1;
  end

  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready)
      q.push_back({bus.out_data, bus.out_keep, bus.out_sop, bus.out_eop});

  task automatic drive(input logic [31:0] d, input logic s, input logic e);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sop = s; bus.in_eop = e;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
  endtask

  task automatic get_word(output logic [37:0] w, output bit ok);
    ok = 1'b0; w = '0;
    for (int c = 0; c < 100; c++) begin
      if (q.size() > 0) begin w = q.pop_front(); ok = 1'b1; break; end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.out_data, bus.out_keep, bus.out_sop, bus.out_eop} !== 39'd0)
      $display("FAIL reset_out got=%h exp=0",
               {bus.out_valid, bus.out_data, bus.out_keep, bus.out_sop, bus.out_eop});
    else passed++;
    total++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow);
    else passed++;
    total++;
    if (protocol_err !== 1'b0) $display("FAIL reset_perr got=%b exp=0", protocol_err);
    else passed++;
  endtask

  task automatic test_basic();
    logic [37:0] w, exp_w [3];
    bit ok;
    exp_w = '{{32'h11223344, 4'hF, 1'b1, 1'b0},
              {32'h55667788, 4'hF, 1'b0, 1'b0},
              {32'hFFD90000, 4'hC, 1'b0, 1'b1}};
    q.delete();
    drive(32'h11223344, 1'b1, 1'b0);
    drive(32'h55667788, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL basic_lat2 got=%b exp=0", bus.out_valid);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1) $display("FAIL basic_lat3 got=%b exp=1", bus.out_valid);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      get_word(w, ok);
      total++;
      if (!ok || w !== exp_w[i]) $display("FAIL basic_w%0d got=%h exp=%h ok=%0d", i, w, exp_w[i], ok);
      else passed++;
    end
  endtask

  task automatic test_stuff();
    logic [37:0] w, exp_w [2];
    bit ok;
    exp_w = '{{32'hFF0000FF, 4'hF, 1'b1, 1'b0},
              {32'h0012FFD9, 4'hF, 1'b0, 1'b1}};
    q.delete();
    drive(32'hFF00FF12, 1'b1, 1'b1);
    idle();
    for (int i = 0; i < 2; i++) begin
      get_word(w, ok);
      total++;
      if (!ok || w !== exp_w[i]) $display("FAIL stuff_w%0d got=%h exp=%h ok=%0d", i, w, exp_w[i], ok);
      else passed++;
    end
  endtask

  task automatic test_overflow();
    int bad;
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    bus.out_ready = 1'b0;
    q.delete();
    for (int k = 0; k < 10; k++) drive(32'hFFFFFFFF, k == 0, 1'b0);
    @(negedge clk);
    total++;
    if (overflow !== 1'b0) $display("FAIL ovf_before got=%b exp=0", overflow);
    else passed++;
    idle();
    @(negedge clk);
    total++;
    if (overflow !== 1'b1) $display("FAIL ovf_after got=%b exp=1", overflow);
    else passed++;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if ({bus.out_valid, bus.out_data, bus.out_keep, bus.out_sop, bus.out_eop} !==
          {1'b1, 32'hFF00FF00, 4'hF, 1'b1, 1'b0}) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL ovf_hold got=%0d unstable cycles exp=0 (data=%h)", bad, bus.out_data);
    else passed++;
    total++;
    if (q.size() !== 0) $display("FAIL ovf_nohs got=%0d handshakes exp=0", q.size());
    else passed++;
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    q.delete();
  endtask

  task automatic test_back_to_back();
    logic [37:0] w, a, b;
    bit ok;
    a = {32'hAABBCCDD, 4'hF, 1'b1, 1'b0};
    b = {32'hFFD90000, 4'hC, 1'b0, 1'b1};
    q.delete();
    for (int k = 0; k < 3; k++) drive(32'hAABBCCDD, 1'b1, 1'b1);
    idle();
    for (int i = 0; i < 6; i++) begin
      get_word(w, ok);
      total++;
      if (!ok || w !== ((i % 2 == 0) ? a : b))
        $display("FAIL b2b_w%0d got=%h exp=%h ok=%0d", i, w, (i % 2 == 0) ? a : b, ok);
      else passed++;
    end
  endtask

  task automatic test_protocol();
    logic [37:0] w, exp_w [4];
    bit ok;
    exp_w = '{{32'h01020304, 4'hF, 1'b1, 1'b0},
              {32'h05060708, 4'hF, 1'b1, 1'b0},
              {32'h0A0B0C0D, 4'hF, 1'b0, 1'b0},
              {32'hFFD90000, 4'hC, 1'b0, 1'b1}};
    q.delete();
    drive(32'hDEADBEEF, 1'b0, 1'b0);
    drive(32'h01020304, 1'b1, 1'b0);
    @(negedge clk);
    total++;
    if (protocol_err !== 1'b1) $display("FAIL perr_idle got=%b exp=1", protocol_err);
    else passed++;
    drive(32'h05060708, 1'b1, 1'b0);
    drive(32'h0A0B0C0D, 1'b0, 1'b1);
    idle();
    for (int i = 0; i < 4; i++) begin
      get_word(w, ok);
      total++;
      if (!ok || w !== exp_w[i]) $display("FAIL perr_w%0d got=%h exp=%h ok=%0d", i, w, exp_w[i], ok);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [37:0] w, exp_w [2];
    bit ok;
    exp_w = '{{32'h11111111, 4'hF, 1'b1, 1'b0},
              {32'hFFD90000, 4'hC, 1'b0, 1'b1}};
    bus.out_ready = 1'b0;
    q.delete();
    drive(32'h01020304, 1'b1, 1'b0);
    drive(32'h05060708, 1'b0, 1'b0);
    drive(32'h090A0B0C, 1'b0, 1'b0);
    drive(32'h0D0E0F10, 1'b0, 1'b0);
    idle();
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.out_valid, overflow, protocol_err} !== 3'b000)
      $display("FAIL rstmid_state got=%b exp=000", {bus.out_valid, overflow, protocol_err});
    else passed++;
    bus.out_ready = 1'b1;
    drive(32'h11111111, 1'b1, 1'b1);
    idle();
    for (int i = 0; i < 2; i++) begin
      get_word(w, ok);
      total++;
      if (!ok || w !== exp_w[i]) $display("FAIL rstmid_w%0d got=%h exp=%h ok=%0d", i, w, exp_w[i], ok);
      else passed++;
    end
    repeat (5) @(posedge clk);
    total++;
    if (q.size() !== 0) $display("FAIL rstmid_extra got=%0d words exp=0", q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuff();
    test_overflow();
    test_back_to_back();
    test_protocol();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
